// File: rtl/guess_pkg.sv
// Shared types and constants for the guess_engine game-control stage.
package guess_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRoll,
        StPlay,
        StCheck,
        StWin,
        StLose
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3), shifting left.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button front end: 2-flop synchroniser, stability counter, rising-edge pulse.
module btn_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_stable_prev;
    logic [CntW-1:0] r_cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CntLast) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stable_prev <= 1'b0;
        end else begin
            r_stable_prev <= r_stable;
        end
    end

    assign o_pulse = r_stable & ~r_stable_prev;

endmodule

// File: rtl/guess_engine.sv
// Number-guessing game control: button pulses, secret roll, guess check, hint bounds.
module guess_engine
    import guess_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MAX_TRIES       = 7
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       load,
    input  logic [3:0] data_in,
    input  logic       diff,
    output logic [3:0] low_bound,
    output logic [3:0] high_bound,
    output logic [3:0] answer,
    output logic [3:0] A_count,
    output logic       win,
    output logic       lose,
    output logic       playing
);

    localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_lfsr;
    logic [3:0] r_answer;
    logic [3:0] r_guess;
    logic [3:0] r_low;
    logic [3:0] r_high;
    logic [3:0] r_count;
    logic       w_start_p;
    logic       w_load_p;
    logic [3:0] w_count_inc;
    logic       w_roll_ok;
    logic       w_guess_ok;

    btn_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_btn (
        .i_clk  (CLK),
        .i_rst  (reset),
        .i_btn  (start),
        .o_pulse(w_start_p)
    );

    btn_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_btn (
        .i_clk  (CLK),
        .i_rst  (reset),
        .i_btn  (load),
        .o_pulse(w_load_p)
    );

    assign w_count_inc = r_count + 4'd1;
    assign w_roll_ok   = (r_lfsr[3:0] <= DIGIT_MAX);
    assign w_guess_ok  = w_load_p && (data_in <= DIGIT_MAX);

    // Free-running secret source; never zero from a nonzero seed.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; restart wins over a simultaneous load in PLAY.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_p) w_next = StRoll;
            end
            StRoll: begin
                if (w_roll_ok) w_next = StPlay;
            end
            StPlay: begin
                if (w_start_p) begin
                    w_next = StRoll;
                end else if (w_guess_ok) begin
                    w_next = StCheck;
                end
            end
            StCheck: begin
                if (r_guess == r_answer) begin
                    w_next = StWin;
                end else if (w_count_inc == MaxTries) begin
                    w_next = StLose;
                end else begin
                    w_next = StPlay;
                end
            end
            StWin, StLose: begin
                if (w_start_p) w_next = StRoll;
            end
            default: w_next = StIdle;
        endcase
    end

    // Game datapath: secret, guess, attempt count and hint bounds.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_answer <= 4'd0;
            r_guess  <= 4'd0;
            r_low    <= 4'd0;
            r_high   <= DIGIT_MAX;
            r_count  <= 4'd0;
        end else begin
            unique case (r_state)
                StRoll: begin
                    if (w_roll_ok) begin
                        r_answer <= r_lfsr[3:0];
                        r_low    <= 4'd0;
                        r_high   <= DIGIT_MAX;
                        r_count  <= 4'd0;
                    end
                end
                StPlay: begin
                    if (!w_start_p && w_guess_ok) r_guess <= data_in;
                end
                StCheck: begin
                    r_count <= w_count_inc;
                    // Guards keep guess+1 / guess-1 inside 0..9 and stop bounds widening.
                    if (diff && (r_guess < r_answer) && (r_guess >= r_low)) begin
                        r_low <= r_guess + 4'd1;
                    end
                    if (diff && (r_guess > r_answer) && (r_guess <= r_high)) begin
                        r_high <= r_guess - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        win     = 1'b0;
        lose    = 1'b0;
        playing = 1'b0;
        unique case (r_state)
            StWin:           win     = 1'b1;
            StLose:          lose    = 1'b1;
            StPlay, StCheck: playing = 1'b1;
            default:         ;
        endcase
    end

    assign low_bound  = r_low;
    assign high_bound = r_high;
    assign answer     = r_answer;
    assign A_count    = r_count;

endmodule

// File: tb/tb_guess_engine.sv
// Randomised bench for guess_engine with a game-level reference model.
`timescale 1ns/1ps
module tb_guess_engine;

    localparam int unsigned DEB   = 4;
    localparam int unsigned TRIES = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_ROLL  = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_CHECK = 3;
    localparam int PH_WIN   = 4;
    localparam int PH_LOSE  = 5;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       load    = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       diff    = 1'b0;
    logic [3:0] low_bound;
    logic [3:0] high_bound;
    logic [3:0] answer;
    logic [3:0] a_count;
    logic       win;
    logic       lose;
    logic       playing;

    guess_engine #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_TRIES      (TRIES)
    ) dut (
        .CLK       (clk),
        .reset     (reset),
        .start     (start),
        .load      (load),
        .data_in   (data_in),
        .diff      (diff),
        .low_bound (low_bound),
        .high_bound(high_bound),
        .answer    (answer),
        .A_count   (a_count),
        .win       (win),
        .lose      (lose),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_phase;
    logic [7:0] m_lfsr;
    int         m_answer, m_low, m_high, m_count, m_guess;
    bit         s_sync1 [2];
    bit         s_sync2 [2];
    bit         s_acc   [2];
    bit         s_prev  [2];
    bit         hist    [2][DEB];

    function automatic logic [7:0] poly_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_lfsr   = 8'hA5;
        m_answer = 0;
        m_low    = 0;
        m_high   = 9;
        m_count  = 0;
        m_guess  = 0;
        for (int b = 0; b < 2; b++) begin
            s_sync1[b] = 0;
            s_sync2[b] = 0;
            s_acc[b]   = 0;
            s_prev[b]  = 0;
            for (int i = 0; i < int'(DEB); i++) hist[b][i] = 0;
        end
    endtask

    task automatic model_step();
        bit sp, lp, all_diff;
        int din;
        sp  = s_acc[0] && !s_prev[0];
        lp  = s_acc[1] && !s_prev[1];
        din = int'(data_in);
        case (m_phase)
            PH_IDLE: if (sp) m_phase = PH_ROLL;
            PH_ROLL: begin
                if (int'(m_lfsr[3:0]) <= 9) begin
                    m_answer = int'(m_lfsr[3:0]);
                    m_low    = 0;
                    m_high   = 9;
                    m_count  = 0;
                    m_phase  = PH_PLAY;
                end
            end
            PH_PLAY: begin
                if (sp) m_phase = PH_ROLL;
                else if (lp && din <= 9) begin
                    m_guess = din;
                    m_phase = PH_CHECK;
                end
            end
            PH_CHECK: begin
                m_count++;
                if (m_guess == m_answer) m_phase = PH_WIN;
                else begin
                    if (m_guess < m_answer && diff && m_guess >= m_low) m_low = m_guess + 1;
                    if (m_guess > m_answer && diff && m_guess <= m_high) m_high = m_guess - 1;
                    m_phase = (m_count == int'(TRIES)) ? PH_LOSE : PH_PLAY;
                end
            end
            default: if (sp) m_phase = PH_ROLL;
        endcase
        m_lfsr = poly_step(m_lfsr);
        // A level is accepted once the synchronised input disagreed for DEB samples running.
        for (int b = 0; b < 2; b++) begin
            s_prev[b] = s_acc[b];
            for (int i = int'(DEB) - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = s_sync2[b];
            all_diff = 1;
            for (int i = 0; i < int'(DEB); i++) if (hist[b][i] == s_acc[b]) all_diff = 0;
            if (all_diff) s_acc[b] = !s_acc[b];
            s_sync2[b] = s_sync1[b];
            s_sync1[b] = (b == 0) ? start : load;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("low_bound", int'(low_bound), m_low);
            check("high_bound", int'(high_bound), m_high);
            check("answer", int'(answer), m_answer);
            check("A_count", int'(a_count), m_count);
            check("win", int'(win), (m_phase == PH_WIN) ? 1 : 0);
            check("lose", int'(lose), (m_phase == PH_LOSE) ? 1 : 0);
            check("playing", int'(playing), (m_phase == PH_PLAY || m_phase == PH_CHECK) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit l, input int d, input int hold);
        @(negedge clk);
        data_in = 4'(d);
        start   = s;
        load    = l;
        idle(hold);
        start = 1'b0;
        load  = 1'b0;
        idle(16);
    endtask

    task automatic new_game();
        press(1'b1, 1'b0, 0, 8);
        idle(12);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_low"}, int'(low_bound), 0);
        check({tag, "_high"}, int'(high_bound), 9);
        check({tag, "_answer"}, int'(answer), 0);
        check({tag, "_count"}, int'(a_count), 0);
        check({tag, "_win"}, int'(win), 0);
        check({tag, "_lose"}, int'(lose), 0);
        check({tag, "_playing"}, int'(playing), 0);
    endtask

    int  a;
    int  g;
    bit  got;
    int  act;

    initial begin
        idle(3);
        reset = 1'b0;
        idle(1);
        check_reset_values("reset");

        // Narrowing: need an answer with room on both sides.
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            new_game();
            if (m_phase == PH_PLAY && m_answer >= 1 && m_answer <= 8) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL roll_budget: no answer in 1..8 within 20 rolls");
        end
        a    = m_answer;
        diff = 1'b1;
        press(1'b0, 1'b1, a - 1, 8);
        check("narrow1_low", int'(low_bound), a);
        check("narrow1_high", int'(high_bound), 9);
        press(1'b0, 1'b1, a + 1, 8);
        check("narrow2_low", int'(low_bound), a);
        check("narrow2_high", int'(high_bound), a);
        check("narrow2_count", int'(a_count), 2);
        press(1'b0, 1'b1, a, 8);
        check("narrow_win", int'(win), 1);
        check("narrow_win_count", int'(a_count), 3);

        // Hints off.
        new_game();
        diff = 1'b0;
        g    = (m_answer == 0) ? 9 : 0;
        press(1'b0, 1'b1, g, 8);
        check("nohint_low", int'(low_bound), 0);
        check("nohint_high", int'(high_bound), 9);
        check("nohint_count", int'(a_count), 1);

        // Out-of-range guess is ignored, then restart beats a simultaneous load.
        press(1'b0, 1'b1, 12, 8);
        check("invalid_count", int'(a_count), 1);
        check("invalid_playing", int'(playing), 1);
        press(1'b1, 1'b1, (m_answer + 1) % 10, 8);
        idle(12);
        check("prio_count", int'(a_count), 0);
        check("prio_playing", int'(playing), 1);

        // Bounce: short glitch rejected, long hold gives one attempt.
        g = (m_answer + 1) % 10;
        @(negedge clk);
        data_in = 4'(g);
        load    = 1'b1;
        idle(3);
        load = 1'b0;
        idle(8);
        load = 1'b1;
        idle(40);
        load = 1'b0;
        idle(16);
        check("bounce_count", int'(a_count), 1);

        // Lose after TRIES wrong guesses; later loads are ignored.
        new_game();
        diff = 1'b1;
        g    = (m_answer + 1) % 10;
        for (int k = 0; k < int'(TRIES); k++) press(1'b0, 1'b1, g, 8);
        check("lose_flag", int'(lose), 1);
        check("lose_count", int'(a_count), int'(TRIES));
        press(1'b0, 1'b1, m_answer, 8);
        check("lose_hold", int'(lose), 1);
        check("lose_hold_win", int'(win), 0);

        // Reset in the middle of a game.
        new_game();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("midreset");
        idle(2);
        reset = 1'b0;
        idle(20);
        check("post_reset_idle", int'(playing), 0);

        // Random play.
        new_game();
        for (int it = 0; it < 60; it++) begin
            act  = $urandom_range(0, 19);
            diff = 1'($urandom_range(0, 1));
            if (act == 0) begin
                @(negedge clk);
                #2 reset = 1'b1;
                idle(2);
                reset = 1'b0;
                idle(2);
            end else if (act <= 2) begin
                press(1'b1, 1'b0, 0, $urandom_range(4, 12));
            end else if (act <= 15) begin
                g = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15);
                press(1'b0, 1'b1, g, $urandom_range(4, 12));
            end else if (act <= 17) begin
                @(negedge clk);
                data_in = 4'($urandom_range(0, 9));
                load    = 1'b1;
                idle($urandom_range(1, 3));
                load = 1'b0;
                idle(12);
            end else begin
                press(1'b1, 1'b1, $urandom_range(0, 9), 8);
            end
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/guess_engine.md
# guess_engine

Game-control stage that sits directly upstream of the seven-segment range display in the number-guessing design. It debounces the start and load buttons and draws a secret digit 0–9 from a free-running LFSR. It checks each guess loaded from the switches, narrows the low/high hint bounds, and counts attempts. The display stage consumes `low_bound`, `high_bound`, `win` and `lose`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable `CLK` cycles before a button level is accepted.
- `MAX_TRIES`, default 7: number of wrong guesses that ends the game in LOSE; range 1–15.

Ports:
- `CLK`  in  1  system clock; every flop uses its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  raw start button, active-high, asynchronous to `CLK`.
- `load`  in  1  raw guess-load button, active-high, asynchronous to `CLK`.
- `data_in`  in  4  guess value from the switches, sampled on the debounced load pulse.
- `diff`  in  1  hint enable: 1 = bounds narrow after each guess, 0 = bounds stay at 0/9.
- `low_bound`  out  4  lowest digit still possible.
- `high_bound`  out  4  highest digit still possible.
- `answer`  out  4  secret digit, for debug and the LED bank.
- `A_count`  out  4  number of valid guesses made in the current game.
- `win`  out  1  high while the FSM is in WIN.
- `lose`  out  1  high while the FSM is in LOSE.
- `playing`  out  1  high while the FSM is in PLAY or CHECK.

## Operation
- Button front end: each raw button goes through a 2-flop synchroniser and then a stability counter. When the accepted level rises, the front end issues a 1-cycle pulse (`start_p`, `load_p`). Holding a button produces exactly one pulse.
- LFSR: 8 bits, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset. It advances every cycle in every state and never reaches 0.
- FSM states are IDLE, ROLL, PLAY, CHECK, WIN, LOSE.
  - IDLE: on `start_p`, go to ROLL.
  - ROLL: if `lfsr[3:0]` ≤ 9, set `answer` to that value, set `low_bound` to 0, `high_bound` to 9 and `A_count` to 0, then go to PLAY. Otherwise stay in ROLL; the LFSR has advanced, so the next cycle retries.
  - PLAY:
    - `start_p` goes to ROLL (restart). It takes priority over a simultaneous `load_p`, which is dropped.
    - `load_p` with `data_in` ≤ 9 latches the value into the `guess` register and goes to CHECK.
    - `load_p` with `data_in` > 9 is ignored: no state change and no count.
  - CHECK (always exactly 1 cycle): `A_count` ← `A_count`+1, then the first matching rule below applies.
    - `guess` == `answer`: go to WIN.
    - `guess` < `answer`: if `diff`=1 and `guess` ≥ `low_bound`, set `low_bound` ← `guess`+1. Go to LOSE if `A_count`+1 == `MAX_TRIES`, otherwise go to PLAY.
    - `guess` > `answer`: if `diff`=1 and `guess` ≤ `high_bound`, set `high_bound` ← `guess`−1. Go to LOSE if `A_count`+1 == `MAX_TRIES`, otherwise go to PLAY.
    - Bounds therefore never widen. Guesses outside the current bounds still count as attempts.
  - WIN / LOSE: all registers hold. `start_p` goes to ROLL. `load_p` is ignored.
- Width rule: `guess`+1 and `guess`−1 are computed in 4 bits. The bound-update guards make underflow and overflow unreachable.

## Timing
- Reset values, applied asynchronously: state IDLE, `low_bound`=0, `high_bound`=9, `answer`=0, `A_count`=0, `win`=0, `lose`=0, `playing`=0, LFSR=8'hA5. Debounce counters and synchroniser flops clear to 0.
- Reset asserted mid-game goes straight to IDLE with the values above. After release, a new `start_p` is required to play.
- Button latency: a raw edge produces its pulse 2 + `DEBOUNCE_CYCLES` cycles later, give or take 1 cycle.
- Guess latency: `load_p` in cycle N puts the FSM in CHECK at cycle N+1. `A_count`, the bounds, `win` and `lose` are updated at the N+1→N+2 edge and are visible from cycle N+2.
- ROLL takes 1 cycle plus 1 cycle per retry.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `guess_pkg` holds:
  - the state enum (IDLE, ROLL, PLAY, CHECK, WIN, LOSE);
  - `DIGIT_MAX`=4'd9;
  - `LFSR_SEED`=8'hA5;
  - the LFSR tap mask.
- Sub-module `btn_pulse`, parameterised by `DEBOUNCE_CYCLES`, contains the synchroniser, stability counter and rising-edge pulse. It is instantiated twice, once for `start` and once for `load`.
- The top level contains the FSM, LFSR, and the answer, guess, bound and count registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: assert `reset` mid-PLAY → on the same edge, state is IDLE, bounds are 0/9, `A_count`=0, `win`=`lose`=0.
- Bounce: a `load` glitch of 3 cycles, then a 40-cycle hold → exactly one `load_p`, and `A_count` increments by exactly 1.
- Narrowing: force `answer`=6 with `diff`=1; guess 3 then guess 8 → bounds become 4/9, then 4/7, `A_count`=2. Then guess 6 → `win`=1 at cycle N+2.
- Hints off: `diff`=0, `answer`=5, guess 2 → bounds stay 0/9, `A_count`=1.
- Invalid guess and priority: `data_in`=12 → no count, still PLAY. Then `start_p` and `load_p` in the same cycle → ROLL, `A_count` reset to 0.
- Lose: `MAX_TRIES`=3, three wrong guesses → `lose`=1 after the third CHECK, and a later `load_p` is ignored. A ROLL that sees `lfsr[3:0]`=13 retries until the value is ≤ 9.
